// File: rtl/seq_booth_mul_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Define SEQ_BOOTH_MUL_RADIX4_EN to build the radix-4 (modified Booth) variant.
package seq_booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] ADD1 = 3'd1;
    localparam logic [2:0] SUB1 = 3'd2;
    localparam logic [2:0] ADD2 = 3'd3;
    localparam logic [2:0] SUB2 = 3'd4;

`ifdef SEQ_BOOTH_MUL_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    function automatic int steps(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 1;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth recoder: maps a 3-bit window {q1, q0, q_-1} to the signed addend 0/+-M/+-2M.
// Combinational, no backpressure; radix-2 callers duplicate q0 into q1.
module booth_recoder
    import seq_booth_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MW    = WIDTH + 1
) (
    input  logic [2:0]       win,
    input  logic [MW-1:0]    m,
    output logic [WIDTH+2:0] addend
);

    localparam int AW = WIDTH + 3;

    logic [2:0]    sel;
    logic [AW-1:0] m_ext;
    logic [AW-1:0] m_dbl;

    assign m_ext = {{(AW-MW){m[MW-1]}}, m};
    assign m_dbl = {m_ext[AW-2:0], 1'b0};

    // With q1 == q0 the table degenerates to the radix-2 rule (only +-M, never +-2M).
    always_comb begin
        sel = NONE;
        case (win)
            3'b001, 3'b010: sel = ADD1;
            3'b011:         sel = ADD2;
            3'b100:         sel = SUB2;
            3'b101, 3'b110: sel = SUB1;
            default:        sel = NONE;
        endcase
    end

    always_comb begin
        addend = '0;
        case (sel)
            ADD1:    addend = m_ext;
            SUB1:    addend = -m_ext;
            ADD2:    addend = m_dbl;
            SUB2:    addend = -m_dbl;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Iterative signed/unsigned Booth multiplier, radix-2 (radix-4 with SEQ_BOOTH_MUL_RADIX4_EN).
// Latency: done pulses STEPS edges after the accept edge (33 radix-2 / 17 radix-4 at WIDTH=32).
// Backpressure: start is ignored while busy; the caller stalls on busy.
module seq_booth_mul
    import seq_booth_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int EW    = RADIX4 ? WIDTH + 2 : WIDTH + 1;
    localparam int PW    = WIDTH + 3;
    localparam int SH    = RADIX4 ? 2 : 1;
    localparam int STEPS = steps(WIDTH, RADIX4);
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t state, nxt_state;
    logic   load, step, finish;

    logic [CW-1:0]      cnt;
    logic [EW-1:0]      m_reg, q_reg, a_ext, b_ext;
    logic [PW-1:0]      p_reg, addend;
    logic               qm1;
    logic [2:0]         win;
    logic signed [PW:0]    sum;
    logic signed [PW+EW:0] full;
    logic [PW+EW-1:0]   acc_nxt;

    assign a_ext = is_signed ? {{(EW-WIDTH){a[WIDTH-1]}}, a} : {{(EW-WIDTH){1'b0}}, a};
    assign b_ext = is_signed ? {{(EW-WIDTH){b[WIDTH-1]}}, b} : {{(EW-WIDTH){1'b0}}, b};

    assign win = RADIX4 ? {q_reg[1], q_reg[0], qm1} : {q_reg[0], q_reg[0], qm1};

    booth_recoder #(
        .WIDTH (WIDTH),
        .MW    (EW)
    ) u_recoder (
        .win    (win),
        .m      (m_reg),
        .addend (addend)
    );

    // One guard bit keeps the sum exact before the arithmetic shift drops it back to PW bits.
    assign sum     = {p_reg[PW-1], p_reg} + {addend[PW-1], addend};
    assign full    = {sum, q_reg};
    assign acc_nxt = (PW+EW)'(full >>> SH);

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nxt_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    nxt_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    nxt_state = RUN;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            m_reg <= '0;
            q_reg <= '0;
            p_reg <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load) begin
                m_reg <= a_ext;
                q_reg <= b_ext;
                p_reg <= '0;
                qm1   <= 1'b0;
                cnt   <= '0;
            end else if (step) begin
                p_reg <= acc_nxt[PW+EW-1:EW];
                q_reg <= acc_nxt[EW-1:0];
                qm1   <= q_reg[SH-1];
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                {hi, lo} <= acc_nxt[2*WIDTH-1:0];
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_booth_mul.sv
// Randomised and directed bench for seq_booth_mul against a plain-arithmetic product model.
module tb_seq_booth_mul;

    localparam int W = 32;
`ifdef SEQ_BOOTH_MUL_RADIX4_EN
    localparam int STEPS = 17;
`else
    localparam int STEPS = 33;
`endif
    localparam int BUDGET = 200;
    localparam int IGN2   = (STEPS > 22) ? 20 : STEPS - 3;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    seq_booth_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        logic signed [2*W-1:0] xs, ys;
        xs = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ys = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xs * ys;
    endfunction

    // Issues one operation from a negedge and waits (bounded) for done; returns observations only.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output int lat, output logic busy_ok,
                         output logic [W-1:0] rh, output logic [W-1:0] rl);
        a = x; b = y; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom);
        lat = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1 && busy !== 1'b0) busy_ok = 1'b0;
        end
        rh = hi; rl = lo;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{32'hFFFFFFFC, 32'h00000012, 32'h00000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [W-1:0] tb [7] = '{32'hFFFFFFFB, 32'h00000014, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h80000000, 32'h00000001};
        logic         ts [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat; logic bok; logic [W-1:0] rh, rl; logic [2*W-1:0] exp;
        for (int i = 0; i < 7; i++) begin
            exp = ref_mul(ta[i], tb[i], ts[i]);
            do_op(ta[i], tb[i], ts[i], lat, bok, rh, rl);
            n_cmp++; if (lat != STEPS) begin n_bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, STEPS); end
            n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy got=%b want=1", i, bok); end
            n_cmp++; if (rh !== exp[2*W-1:W]) begin n_bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, rh, exp[2*W-1:W]); end
            n_cmp++; if (rl !== exp[W-1:0]) begin n_bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, rl, exp[W-1:0]); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_random();
        int lat; logic bok; logic [W-1:0] x, y, rh, rl; logic s; logic [2*W-1:0] exp;
        for (int i = 0; i < 24; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            if (i % 6 == 1) x = 32'h80000000;
            if (i % 6 == 3) y = 32'hFFFFFFFF;
            exp = ref_mul(x, y, s);
            do_op(x, y, s, lat, bok, rh, rl);
            n_cmp++; if (lat != STEPS) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, STEPS); end
            n_cmp++; if ({rh, rl} !== exp) begin n_bad++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got=%h want=%h", i, x, y, s, {rh, rl}, exp); end
            repeat (i % 3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y; logic s; logic [2*W-1:0] exp; int lat;
        x = 32'hDEADBEEF; y = 32'h12345678; s = 1'b1;
        exp = ref_mul(x, y, s);
        a = x; b = y; is_signed = s; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < BUDGET) begin
            if (lat == 5 || lat == IGN2) begin
                start = 1'b1; a = $urandom; b = $urandom; is_signed = ~is_signed;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != STEPS) begin n_bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, STEPS); end
        n_cmp++; if ({hi, lo} !== exp) begin n_bad++; $display("FAIL ignore_product got=%h want=%h", {hi, lo}, exp); end
        // Still in the DONE cycle: request the next operation immediately.
        a = 32'd3; b = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%b want=0", done); end
        lat = 0;
        while (done !== 1'b1 && lat < BUDGET) begin @(negedge clk); lat++; end
        exp = ref_mul(32'd3, 32'd7, 1'b0);
        n_cmp++; if (lat != STEPS) begin n_bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, STEPS); end
        n_cmp++; if ({hi, lo} !== exp) begin n_bad++; $display("FAIL b2b_product got=%h want=%h", {hi, lo}, exp); end
        @(negedge clk);
    endtask

    task automatic test_clr();
        int seen;
        a = 32'h00012345; b = 32'h00000321; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_pre_busy got=%b want=1", busy); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clr_done got=%b want=0", done); end
        n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL clr_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL clr_lo got=%h want=0", lo); end
        seen = 0;
        repeat (STEPS + 10) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL clr_no_done got=%0d want=0", seen); end
        clr = 1'b1; start = 1'b1; a = 32'h5; b = 32'h6;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        seen = 0;
        repeat (5) begin @(negedge clk); if (busy === 1'b1 || done === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL clr_start_idle got=%0d want=0", seen); end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
